// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: control codes, FSM encoding and
// requester-id sizing.
package alu_pkg;

   localparam logic [3:0] CTRL_AND   = 4'd0;
   localparam logic [3:0] CTRL_OR    = 4'd1;
   localparam logic [3:0] CTRL_ADDU  = 4'd2;
   localparam logic [3:0] CTRL_SLL   = 4'd3;
   localparam logic [3:0] CTRL_AND_N = 4'd4;
   localparam logic [3:0] CTRL_OR_N  = 4'd5;
   localparam logic [3:0] CTRL_SUBU  = 4'd6;
   localparam logic [3:0] CTRL_SLT   = 4'd7;
   localparam logic [3:0] CTRL_LUI   = 4'd8;

   localparam int ID_W = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Requester id to its one-hot port bit.
   function automatic logic [1:0] id_onehot(input logic [ID_W-1:0] id);
      logic [1:0] oh;
      if (id == 1'b1) begin
         oh = 2'b10;
      end else begin
         oh = 2'b01;
      end
      return oh;
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; unused control codes produce a zero result and
// a clear sign flag.
module alu_arbiter_alu
   import alu_pkg::*;
(
   input  logic [3:0]  ctrl,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   output logic [31:0] result,
   output logic        sign
);

   logic lt_s;
   logic eq_s;

   assign lt_s = (a < b);
   assign eq_s = (a == b);

   // Result and sign selection by control code.
   always_comb begin
      result = 32'd0;
      sign   = 1'b0;
      case (ctrl)
         CTRL_AND:   result = a & b;
         CTRL_OR:    result = a | b;
         CTRL_ADDU:  result = a + b;
         CTRL_SLL:   result = b << shamt;
         CTRL_AND_N: result = a & ~b;
         CTRL_OR_N:  result = a | ~b;
         CTRL_SUBU: begin
            result = a - b;
            sign   = eq_s;
         end
         CTRL_SLT: begin
            result = {31'd0, lt_s};
            sign   = lt_s;
         end
         CTRL_LUI:   result = b << 5'd16;
         default: begin
            result = 32'd0;
            sign   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-port front end for the shared ALU; one operation in flight,
// result held in registers until the issuing requester consumes it.
module alu_arbiter
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [3:0]  req0_ctrl,
   input  logic [3:0]  req1_ctrl,
   input  logic [31:0] req0_a,
   input  logic [31:0] req1_a,
   input  logic [31:0] req0_b,
   input  logic [31:0] req1_b,
   input  logic [4:0]  req0_shamt,
   input  logic [4:0]  req1_shamt,
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_sign
);

   state_t            state_r;
   state_t            state_next_s;
   logic [ID_W-1:0]   last_r;
   logic [ID_W-1:0]   owner_r;
   logic [ID_W-1:0]   grant_id_s;
   logic              grant_any_s;
   logic              accept_s;
   logic [3:0]        ctrl_r;
   logic [31:0]       a_r;
   logic [31:0]       b_r;
   logic [4:0]        shamt_r;
   logic [31:0]       alu_result_s;
   logic              alu_sign_s;
   logic [31:0]       result_r;
   logic              sign_r;
   logic [1:0]        rsp_valid_r;

   // Tie goes to whichever requester was not served last.
   always_comb begin
      grant_id_s  = 1'b0;
      grant_any_s = 1'b0;
      if (req_valid == 2'b11) begin
         grant_id_s  = ~last_r;
         grant_any_s = 1'b1;
      end else if (req_valid[0]) begin
         grant_id_s  = 1'b0;
         grant_any_s = 1'b1;
      end else if (req_valid[1]) begin
         grant_id_s  = 1'b1;
         grant_any_s = 1'b1;
      end else begin
         grant_id_s  = 1'b0;
         grant_any_s = 1'b0;
      end
   end

   // Next-state, accept and ready decode.
   always_comb begin
      state_next_s = state_r;
      accept_s     = 1'b0;
      req_ready    = 2'b00;
      case (state_r)
         IDLE: begin
            if (grant_any_s && !reset) begin
               req_ready    = id_onehot(grant_id_s);
               accept_s     = 1'b1;
               state_next_s = EXEC;
            end else begin
               state_next_s = IDLE;
            end
         end
         EXEC: state_next_s = RESP;
         RESP: begin
            if (rsp_ready[owner_r]) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = RESP;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State, round-robin pointer and operand capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         last_r  <= 1'b1;
         owner_r <= 1'b0;
         ctrl_r  <= 4'd0;
         a_r     <= 32'd0;
         b_r     <= 32'd0;
         shamt_r <= 5'd0;
      end else begin
         state_r <= state_next_s;
         if (accept_s) begin
            last_r  <= grant_id_s;
            owner_r <= grant_id_s;
            if (grant_id_s == 1'b1) begin
               ctrl_r  <= req1_ctrl;
               a_r     <= req1_a;
               b_r     <= req1_b;
               shamt_r <= req1_shamt;
            end else begin
               ctrl_r  <= req0_ctrl;
               a_r     <= req0_a;
               b_r     <= req0_b;
               shamt_r <= req0_shamt;
            end
         end
      end
   end

   alu_arbiter_alu u_alu (
      .ctrl   (ctrl_r),
      .a      (a_r),
      .b      (b_r),
      .shamt  (shamt_r),
      .result (alu_result_s),
      .sign   (alu_sign_s)
   );

   // Response registers: loaded only on leaving EXEC, valid dropped on consume.
   always_ff @(posedge clk) begin
      if (reset) begin
         result_r    <= 32'd0;
         sign_r      <= 1'b0;
         rsp_valid_r <= 2'b00;
      end else if (state_r == EXEC) begin
         result_r    <= alu_result_s;
         sign_r      <= alu_sign_s;
         rsp_valid_r <= id_onehot(owner_r);
      end else if ((state_r == RESP) && rsp_ready[owner_r]) begin
         rsp_valid_r <= 2'b00;
      end else begin
         rsp_valid_r <= rsp_valid_r;
      end
   end

   assign rsp_valid  = rsp_valid_r;
   assign rsp_result = result_r;
   assign rsp_sign   = sign_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scenario bench for alu_arbiter: scoreboard fed at accept, drained at each
// response handshake, plus per-scenario cycle and value checks.
module tb_alu_arbiter;

   logic        clk;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req0_ctrl, req1_ctrl;
   logic [31:0] req0_a, req1_a, req0_b, req1_b;
   logic [4:0]  req0_shamt, req1_shamt;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_sign;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int          id;
      logic [31:0] res;
      logic        sgn;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   alu_arbiter dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
      .req0_a(req0_a), .req1_a(req1_a),
      .req0_b(req0_b), .req1_b(req1_b),
      .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_sign(rsp_sign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model(input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh,
                                 output logic [31:0] r, output logic s);
      r = 32'd0;
      s = 1'b0;
      case (c)
         4'd0: r = a & b;
         4'd1: r = a | b;
         4'd2: r = a + b;
         4'd3: r = b << sh;
         4'd4: r = a & ~b;
         4'd5: r = a | ~b;
         4'd6: begin r = a - b; s = (a == b); end
         4'd7: begin r = (a < b) ? 32'd1 : 32'd0; s = (a < b); end
         4'd8: r = {b[15:0], 16'h0000};
         default: begin r = 32'd0; s = 1'b0; end
      endcase
   endfunction

   // Scoreboard: push on accept, pop and compare on response handshake.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
      end else begin
         if (req_valid[0] && req_ready[0]) begin
            mon_e.id = 0;
            model(req0_ctrl, req0_a, req0_b, req0_shamt, mon_e.res, mon_e.sgn);
            sb.push_back(mon_e);
         end else if (req_valid[1] && req_ready[1]) begin
            mon_e.id = 1;
            model(req1_ctrl, req1_a, req1_b, req1_shamt, mon_e.res, mon_e.sgn);
            sb.push_back(mon_e);
         end
         for (int p = 0; p < 2; p++) begin
            if (rsp_valid[p] && rsp_ready[p]) begin
               tests++;
               if (sb.size() == 0) begin
                  fails++;
                  $display("FAIL sb_unexpected: port %0d result %h with nothing expected", p, rsp_result);
               end else begin
                  mon_e = sb.pop_front();
                  if (mon_e.id != p || rsp_result !== mon_e.res || rsp_sign !== mon_e.sgn) begin
                     fails++;
                     $display("FAIL sb_rsp: got port %0d res %h sign %b, want port %0d res %h sign %b",
                              p, rsp_result, rsp_sign, mon_e.id, mon_e.res, mon_e.sgn);
                  end
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input int p, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
      if (p == 0) begin
         req0_ctrl = c; req0_a = a; req0_b = b; req0_shamt = sh;
         req_valid[0] = 1'b1;
      end else begin
         req1_ctrl = c; req1_a = a; req1_b = b; req1_shamt = sh;
         req_valid[1] = 1'b1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic wait_ready(input int max, output int cyc);
      cyc = -1;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic wait_rsp(input int max, output int cyc);
      cyc = -1;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (rsp_valid != 2'b00) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 4'd2, 32'd1, 32'd1, 5'd0);
      drive(1, 4'd2, 32'd2, 32'd2, 5'd0);
      @(negedge clk);
      tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", req_ready); end
      tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
      tests++; if (rsp_result !== 32'd0) begin fails++; $display("FAIL reset_result: got %h want 0", rsp_result); end
      tests++; if (rsp_sign !== 1'b0) begin fails++; $display("FAIL reset_sign: got %b want 0", rsp_sign); end
      @(posedge clk);
      #1 reset = 1'b0;
      req_valid = 2'b00;
   endtask

   task automatic test_single();
      rsp_ready = 2'b11;
      drive(0, 4'd2, 32'd5, 32'd7, 5'd0);
      @(negedge clk);
      tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_ready: got %b want 01", req_ready); end
      @(posedge clk); #1 req_valid[0] = 1'b0;
      @(negedge clk);
      tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL single_exec: rsp_valid %b want 00", rsp_valid); end
      @(negedge clk);
      tests++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd12 || rsp_sign !== 1'b0) begin
         fails++; $display("FAIL single_rsp: valid %b res %h sign %b, want 01 0000000c 0", rsp_valid, rsp_result, rsp_sign);
      end
      @(negedge clk);
      tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL single_done: rsp_valid %b want 00", rsp_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_tie();
      do_reset();
      rsp_ready = 2'b11;
      drive(0, 4'd6, 32'd9, 32'd9, 5'd0);
      drive(1, 4'd7, 32'd3, 32'd4, 5'd0);
      @(negedge clk);
      tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL tie_first: got %b want 01", req_ready); end
      @(posedge clk); #1 req_valid[0] = 1'b0;
      @(negedge clk);
      tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL tie_busy: got %b want 00", req_ready); end
      @(negedge clk);
      tests++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd0 || rsp_sign !== 1'b1) begin
         fails++; $display("FAIL tie_rsp0: valid %b res %h sign %b, want 01 00000000 1", rsp_valid, rsp_result, rsp_sign);
      end
      @(negedge clk);
      tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL tie_second: cycle 3 ready %b want 10", req_ready); end
      @(posedge clk); #1 req_valid[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests++; if (rsp_valid !== 2'b10 || rsp_result !== 32'd1 || rsp_sign !== 1'b1) begin
         fails++; $display("FAIL tie_rsp1: valid %b res %h sign %b, want 10 00000001 1", rsp_valid, rsp_result, rsp_sign);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int c;
      rsp_ready = 2'b01;
      drive(1, 4'd8, 32'd0, 32'h0000_1234, 5'd0);
      wait_ready(10, c);
      tests++; if (c < 0 || req_ready !== 2'b10) begin fails++; $display("FAIL bp_accept: ready %b after %0d, want 10", req_ready, c); end
      @(posedge clk); #1 req_valid[1] = 1'b0;
      drive(0, 4'd0, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
      wait_rsp(10, c);
      tests++; if (c !== 1 || rsp_valid !== 2'b10) begin fails++; $display("FAIL bp_rsp: valid %b after %0d, want 10 after 1", rsp_valid, c); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (rsp_valid !== 2'b10 || rsp_result !== 32'h1234_0000 || req_ready !== 2'b00) begin
            fails++; $display("FAIL bp_hold: cycle %0d valid %b res %h ready %b, want 10 12340000 00", i, rsp_valid, rsp_result, req_ready);
         end
      end
      @(posedge clk); #1 rsp_ready = 2'b11;
      @(negedge clk);
      tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_release: ready %b want 00", req_ready); end
      @(negedge clk);
      tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL bp_next: ready %b want 01", req_ready); end
      @(posedge clk); #1 req_valid[0] = 1'b0;
      wait_rsp(10, c);
      tests++; if (c < 0 || rsp_valid !== 2'b01 || rsp_result !== 32'h0000_F000) begin
         fails++; $display("FAIL bp_after: valid %b res %h, want 01 0000f000", rsp_valid, rsp_result);
      end
      @(posedge clk); #1;
   endtask

   logic [3:0]  t_ctrl [11] = '{4'd3, 4'd4, 4'd15, 4'd2, 4'd6, 4'd5, 4'd1, 4'd7, 4'd8, 4'd0, 4'd7};
   logic [31:0] t_a    [11] = '{32'd0, 32'hFF, 32'hFFFF, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'h0F00,
                                32'd5, 32'hABCD, 32'hFF00_FF00, 32'hFFFF_FFFF};
   logic [31:0] t_b    [11] = '{32'd1, 32'h0F, 32'h1234, 32'd1, 32'd5, 32'hFFFF_0000, 32'h00F0,
                                32'd5, 32'h8001, 32'h0FF0_0FF0, 32'd1};
   logic [4:0]  t_sh   [11] = '{5'd31, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
   logic [31:0] t_res  [11] = '{32'h8000_0000, 32'hF0, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'h0000_FFFF,
                                32'h0FF0, 32'd0, 32'h8001_0000, 32'h0F00_0F00, 32'd0};
   logic        t_sgn  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   task automatic test_ops();
      int c;
      int p;
      logic [1:0] oh;
      rsp_ready = 2'b11;
      for (int i = 0; i < 11; i++) begin
         p  = i % 2;
         oh = (p == 0) ? 2'b01 : 2'b10;
         drive(p, t_ctrl[i], t_a[i], t_b[i], t_sh[i]);
         wait_ready(10, c);
         tests++; if (c < 0 || req_ready !== oh) begin fails++; $display("FAIL ops_accept[%0d]: ready %b want %b", i, req_ready, oh); end
         @(posedge clk); #1 req_valid = 2'b00;
         wait_rsp(10, c);
         tests++;
         if (c !== 1 || rsp_valid !== oh || rsp_result !== t_res[i] || rsp_sign !== t_sgn[i]) begin
            fails++; $display("FAIL ops_rsp[%0d]: lat %0d valid %b res %h sign %b, want 1 %b %h %b",
                              i, c, rsp_valid, rsp_result, rsp_sign, oh, t_res[i], t_sgn[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_fairness();
      int c;
      logic [1:0] want;
      do_reset();
      rsp_ready = 2'b11;
      drive(0, 4'd2, 32'd100, 32'd1, 5'd0);
      drive(1, 4'd6, 32'd50, 32'd8, 5'd0);
      for (int k = 0; k < 6; k++) begin
         want = (k % 2 == 0) ? 2'b01 : 2'b10;
         wait_ready(12, c);
         tests++;
         if (c < 0 || req_ready !== want || (k > 0 && c !== 2)) begin
            fails++; $display("FAIL fair_grant[%0d]: ready %b gap %0d, want %b gap 2", k, req_ready, c, want);
         end
         @(posedge clk); #1;
         if (k == 5) req_valid = 2'b00;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_midop();
      int c;
      rsp_ready = 2'b11;
      drive(0, 4'd2, 32'd1, 32'd2, 5'd0);
      wait_ready(10, c);
      tests++; if (c < 0 || req_ready !== 2'b01) begin fails++; $display("FAIL mid_accept: ready %b want 01", req_ready); end
      @(posedge clk); #1 req_valid = 2'b00;
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL mid_dropped: cycle %0d rsp_valid %b want 00", i, rsp_valid); end
      end
      tests++; if (rsp_result !== 32'd0) begin fails++; $display("FAIL mid_result: got %h want 0", rsp_result); end
      @(posedge clk); #1;
      drive(0, 4'd0, 32'hF, 32'h3, 5'd0);
      drive(1, 4'd1, 32'hF0, 32'h1, 5'd0);
      @(negedge clk);
      tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL mid_tie: ready %b want 01", req_ready); end
      @(posedge clk); #1 req_valid[0] = 1'b0;
      wait_ready(10, c);
      tests++; if (c < 0 || req_ready !== 2'b10) begin fails++; $display("FAIL mid_second: ready %b want 10", req_ready); end
      @(posedge clk); #1 req_valid[1] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req0_ctrl = 4'd0; req1_ctrl = 4'd0;
      req0_a = 32'd0; req1_a = 32'd0;
      req0_b = 32'd0; req1_b = 32'd0;
      req0_shamt = 5'd0; req1_shamt = 5'd0;
      @(posedge clk); #1;
      test_reset();
      test_single();
      test_tie();
      test_backpressure();
      test_ops();
      test_fairness();
      test_reset_midop();
      tests++;
      if (sb.size() != 0) begin
         fails++; $display("FAIL sb_leftover: %0d responses never delivered", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
